// File: rtl/fc_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fc_update_scheduler
// Purpose  : VC0 credit-return counters and UpdateFC DLLP request scheduler.
//            Build option FC_INFINITE_CPL_EN: completion credits are infinite.
// Revision : 1.0 - initial release
// ============================================================================
module fc_update_scheduler #(
    parameter int HDR_CW       = 8,
    parameter int DATA_CW      = 12,
    parameter int INIT_HDR     = 16,
    parameter int INIT_DATA    = 16,
    parameter int HDR_THRESH   = 4,
    parameter int DATA_THRESH  = 8,
    parameter int TIMER_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ph_rel_i,
    input  logic               pd_rel_i,
    input  logic               nph_rel_i,
    input  logic               npd_rel_i,
    input  logic               ch_rel_i,
    input  logic               cd_rel_i,
    output logic               dllp_valid_o,
    input  logic               dllp_ready_i,
    output logic [1:0]         dllp_type_o,
    output logic [HDR_CW-1:0]  dllp_hdr_fc_o,
    output logic [DATA_CW-1:0] dllp_data_fc_o,
    output logic [2:0]         pending_o
);

`ifdef FC_INFINITE_CPL_EN
    localparam int NCLS = 2;
`else
    localparam int NCLS = 3;
`endif
    localparam int TW = (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q;
    logic [HDR_CW-1:0]  alloc_h_q [3];
    logic [HDR_CW-1:0]  adv_h_q   [3];
    logic [HDR_CW-1:0]  dh        [3];
    logic [DATA_CW-1:0] alloc_d_q [3];
    logic [DATA_CW-1:0] adv_d_q   [3];
    logic [DATA_CW-1:0] dd        [3];
    logic [2:0]         rel_h;
    logic [2:0]         rel_d;
    logic [TW-1:0]      timer_q;
    logic [TW-1:0]      timer_d;
    logic [2:0]         tflag_q;
    logic [2:0]         tflag_d;
    logic [2:0]         pending_q;
    logic [2:0]         pending_d;
    logic [3:0]         pend_ext;
    logic [1:0]         rr_q;
    logic [1:0]         rr_next;
    logic [1:0]         pick;
    logic [1:0]         cand;
    logic [2:0]         cand_sum;
    logic               pick_vld;
    logic               accept;
    logic               wrap;

`ifdef FC_INFINITE_CPL_EN
    logic unused_cpl_rel;
    assign unused_cpl_rel = ch_rel_i | cd_rel_i;
    assign rel_h = {1'b0, nph_rel_i, ph_rel_i};
    assign rel_d = {1'b0, npd_rel_i, pd_rel_i};
`else
    assign rel_h = {ch_rel_i, nph_rel_i, ph_rel_i};
    assign rel_d = {cd_rel_i, npd_rel_i, pd_rel_i};
`endif

    assign pending_o = pending_q;
    assign pend_ext  = {1'b0, pending_q};

    // Pending sees the post-acceptance timer flag so a refresh is not re-issued.
    always_comb begin
        accept  = (state_q == SEND) && dllp_ready_i;
        wrap    = (timer_q == TW'(TIMER_CYCLES - 1));
        timer_d = wrap ? '0 : timer_q + TW'(1);
        for (int c = 0; c < 3; c++) begin
            dh[c]        = alloc_h_q[c] - adv_h_q[c];
            dd[c]        = alloc_d_q[c] - adv_d_q[c];
            tflag_d[c]   = wrap | (tflag_q[c] & ~(accept && (dllp_type_o == 2'(c))));
            pending_d[c] = (dh[c] >= HDR_CW'(HDR_THRESH)) |
                           (dd[c] >= DATA_CW'(DATA_THRESH)) | tflag_d[c];
        end
`ifdef FC_INFINITE_CPL_EN
        tflag_d[2]   = 1'b0;
        pending_d[2] = 1'b0;
`endif
    end

    // Descending scan: the candidate closest to the rr pointer is written last.
    always_comb begin
        pick     = rr_q;
        pick_vld = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int k = NCLS - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_q} + 3'(k);
            cand     = (cand_sum >= 3'(NCLS)) ? 2'(cand_sum - 3'(NCLS)) : cand_sum[1:0];
            if (pend_ext[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
        rr_next = (dllp_type_o == 2'(NCLS - 1)) ? 2'd0 : dllp_type_o + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                alloc_h_q[c] <= HDR_CW'(INIT_HDR);
                alloc_d_q[c] <= DATA_CW'(INIT_DATA);
            end
            timer_q   <= '0;
            tflag_q   <= '0;
            pending_q <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                alloc_h_q[c] <= alloc_h_q[c] + HDR_CW'(rel_h[c]);
                alloc_d_q[c] <= alloc_d_q[c] + DATA_CW'(rel_d[c]);
            end
            timer_q   <= timer_d;
            tflag_q   <= tflag_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_q           <= 2'd0;
            dllp_valid_o   <= 1'b0;
            dllp_type_o    <= 2'd0;
            dllp_hdr_fc_o  <= '0;
            dllp_data_fc_o <= '0;
            for (int c = 0; c < 3; c++) begin
                adv_h_q[c] <= HDR_CW'(INIT_HDR);
                adv_d_q[c] <= DATA_CW'(INIT_DATA);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        dllp_type_o    <= pick;
                        dllp_hdr_fc_o  <= alloc_h_q[pick];
                        dllp_data_fc_o <= alloc_d_q[pick];
                        adv_h_q[pick]  <= alloc_h_q[pick];
                        adv_d_q[pick]  <= alloc_d_q[pick];
                        dllp_valid_o   <= 1'b1;
                        state_q        <= SEND;
                    end
                end
                SEND: begin
                    if (dllp_ready_i) begin
                        dllp_valid_o <= 1'b0;
                        rr_q         <= rr_next;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_update_scheduler
// Purpose  : Self-checking bench for fc_update_scheduler (vectors, sequences,
//            randomized traffic against a credit-accounting reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_update_scheduler;

    localparam int TC = 64;
`ifdef FC_INFINITE_CPL_EN
    localparam int NCLS = 2;
`else
    localparam int NCLS = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ph = 1'b0, pd = 1'b0, nph = 1'b0, npd = 1'b0, ch = 1'b0, cd = 1'b0;
    logic        ready = 1'b0;
    logic        dllp_valid;
    logic [1:0]  dllp_type;
    logic [7:0]  dllp_hdr_fc;
    logic [11:0] dllp_data_fc;
    logic [2:0]  pending;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fc_update_scheduler #(.TIMER_CYCLES(TC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ph_rel_i       (ph),
        .pd_rel_i       (pd),
        .nph_rel_i      (nph),
        .npd_rel_i      (npd),
        .ch_rel_i       (ch),
        .cd_rel_i       (cd),
        .dllp_valid_o   (dllp_valid),
        .dllp_ready_i   (ready),
        .dllp_type_o    (dllp_type),
        .dllp_hdr_fc_o  (dllp_hdr_fc),
        .dllp_data_fc_o (dllp_data_fc),
        .pending_o      (pending)
    );

    // Reference model: integer release totals, the totals at the last
    // advertisement, and an outstanding-request record.
    int   m_rel_h [3], m_rel_d [3], m_adv_h [3], m_adv_d [3];
    bit   m_tf [3], m_pend [3];
    bit   m_busy, m_valid;
    int   m_cur, m_nxt, m_edges, m_type, m_hdr, m_data;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_rel_h[c] = 0; m_rel_d[c] = 0; m_adv_h[c] = 0; m_adv_d[c] = 0;
            m_tf[c] = 0; m_pend[c] = 0;
        end
        m_busy = 0; m_valid = 0; m_cur = 0; m_nxt = 0; m_edges = 0;
        m_type = 0; m_hdr = 0; m_data = 0;
    endtask

    task automatic model_edge(input logic [5:0] rel, input logic rdy);
        bit wrap, acc, found;
        bit n_tf [3], n_pend [3];
        int c;
        wrap = (m_edges % TC) == TC - 1;
        acc  = m_busy && rdy;
        for (int k = 0; k < 3; k++) begin
            n_tf[k]   = (k < NCLS) && (wrap || (m_tf[k] && !(acc && m_cur == k)));
            n_pend[k] = (k < NCLS) && ((((m_rel_h[k] - m_adv_h[k]) % 256) >= 4) ||
                                       (((m_rel_d[k] - m_adv_d[k]) % 4096) >= 8) || n_tf[k]);
        end
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < NCLS; k++) begin
                c = (m_nxt + k) % NCLS;
                if (!found && m_pend[c]) begin
                    found = 1; m_busy = 1; m_valid = 1; m_cur = c; m_type = c;
                    m_hdr = (16 + m_rel_h[c]) % 256;
                    m_data = (16 + m_rel_d[c]) % 4096;
                    m_adv_h[c] = m_rel_h[c];
                    m_adv_d[c] = m_rel_d[c];
                end
            end
        end else if (acc) begin
            m_busy = 0; m_valid = 0; m_nxt = (m_cur + 1) % NCLS;
        end
        for (int k = 0; k < 3; k++) begin
            m_tf[k] = n_tf[k]; m_pend[k] = n_pend[k];
        end
        m_rel_h[0] += int'(rel[0]); m_rel_d[0] += int'(rel[1]);
        m_rel_h[1] += int'(rel[2]); m_rel_d[1] += int'(rel[3]);
        if (NCLS == 3) begin
            m_rel_h[2] += int'(rel[4]); m_rel_d[2] += int'(rel[5]);
        end
        m_edges++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {6'd0, dllp_valid, dllp_type, dllp_hdr_fc, dllp_data_fc, pending};
    endfunction

    function automatic logic [31:0] model_vec();
        return {6'd0, 1'(m_valid), 2'(m_type), 8'(m_hdr), 12'(m_data),
                1'(m_pend[2]), 1'(m_pend[1]), 1'(m_pend[0])};
    endfunction

    // Inputs change at negedge; outputs are sampled 1ns after the posedge.
    task automatic step(input logic [5:0] rel, input logic rdy);
        @(negedge clk);
        {cd, ch, npd, nph, pd, ph} = rel;
        ready = rdy;
        @(posedge clk);
        model_edge(rel, rdy);
        #1;
        chk("cycle_vs_model", dut_vec(), model_vec());
    endtask

    // Called 1ns after a posedge; asserts reset asynchronously between edges.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        {cd, ch, npd, nph, pd, ph} = 6'd0;
        ready = 1'b0;
        model_reset();
        #1;
        chk("reset_outputs", dut_vec(), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [5:0]  rel;
        logic        rdy;
        logic        v;
        logic [1:0]  t;
        logic [7:0]  h;
        logic [11:0] d;
        logic [2:0]  p;
    } vec_t;

    localparam logic [5:0] R_PH  = 6'b000001;
    localparam logic [5:0] R_NPD = 6'b001000;
    localparam logic [5:0] R_CH  = 6'b010000;
    localparam logic [5:0] R_ALL_H = 6'b010101;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        logic [21:0] reqs [$];
        int ev [7];
        int et [7];
        int last_hdr, n_cpl, k;

        tbl[0] = '{R_PH, 1'b1, 1'b0, 2'd0, 8'd0,  12'd0,  3'b000};
        tbl[1] = '{R_PH, 1'b1, 1'b0, 2'd0, 8'd0,  12'd0,  3'b000};
        tbl[2] = '{R_PH, 1'b1, 1'b0, 2'd0, 8'd0,  12'd0,  3'b000};
        tbl[3] = '{R_PH, 1'b1, 1'b0, 2'd0, 8'd0,  12'd0,  3'b000};
        tbl[4] = '{6'd0, 1'b1, 1'b0, 2'd0, 8'd0,  12'd0,  3'b001};
        tbl[5] = '{6'd0, 1'b1, 1'b1, 2'd0, 8'd20, 12'd16, 3'b001};
        tbl[6] = '{6'd0, 1'b1, 1'b0, 2'd0, 8'd20, 12'd16, 3'b000};
        tbl[7] = '{6'd0, 1'b1, 1'b0, 2'd0, 8'd20, 12'd16, 3'b000};

        model_reset();
        @(posedge clk);
        do_reset();

        // Threshold on the fourth PH release, accepted immediately.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rel, tbl[i].rdy);
            chk($sformatf("tbl_%0d", i), dut_vec(),
                {6'd0, tbl[i].v, tbl[i].t, tbl[i].h, tbl[i].d, tbl[i].p});
        end

        // NPD threshold with the transmitter stalled for ten cycles.
        do_reset();
        for (int i = 0; i < 8; i++) step(R_NPD, 1'b0);
        step(6'd0, 1'b0);
        step(6'd0, 1'b0);
        chk("npd_req", {dllp_valid, dllp_type, dllp_hdr_fc, dllp_data_fc},
            {1'b1, 2'd1, 8'd16, 12'd24});
        for (int i = 0; i < 9; i++) begin
            step(6'd0, 1'b0);
            chk("npd_hold", {dllp_valid, dllp_type, dllp_hdr_fc, dllp_data_fc},
                {1'b1, 2'd1, 8'd16, 12'd24});
        end
        step(6'd0, 1'b1);
        chk("npd_accept_drop", 32'(dllp_valid), 32'd0);

        // Every class crosses threshold together: round-robin order with gaps.
        do_reset();
        for (int i = 0; i < 4; i++) step(R_ALL_H, 1'b1);
        ev = '{0, 1, 0, 1, 0, (NCLS == 3) ? 1 : 0, 0};
        et = '{0, 0, 0, 1, 0, 2, 0};
        for (int i = 0; i < 7; i++) begin
            step(6'd0, 1'b1);
            chk($sformatf("arb_valid_%0d", i), 32'(dllp_valid), 32'(ev[i]));
            if (ev[i] != 0) begin
                chk($sformatf("arb_type_%0d", i), 32'(dllp_type), 32'(et[i]));
                chk($sformatf("arb_hdr_%0d", i), 32'(dllp_hdr_fc), 32'd20);
            end
        end

        // Timer refresh without any releases.
        do_reset();
        reqs.delete();
        for (int i = 0; i < TC + 10; i++) begin
            step(6'd0, 1'b1);
            if (dllp_valid) reqs.push_back({dllp_type, dllp_hdr_fc, dllp_data_fc});
        end
        chk("refresh_count", 32'(reqs.size()), 32'(NCLS));
        for (int i = 0; i < reqs.size() && i < NCLS; i++)
            chk($sformatf("refresh_%0d", i), 32'(reqs[i]), {10'd0, 2'(i), 8'd16, 12'd16});

        // Header counter wrap, then reset in the middle of a request.
        do_reset();
        last_hdr = -1;
        for (int i = 0; i < 270; i++) begin
            step((i < 250) ? R_PH : 6'd0, 1'b1);
            if (dllp_valid && dllp_type == 2'd0) last_hdr = int'(dllp_hdr_fc);
        end
        chk("wrap_last_hdr", 32'(last_hdr), 32'd10);
        k = 0;
        while (!dllp_valid && k < 20) begin
            step((k < 4) ? R_PH : 6'd0, 1'b0);
            k++;
        end
        chk("midsend_valid_before_reset", 32'(dllp_valid), 32'd1);
        do_reset();
        last_hdr = -1;
        for (int i = 0; i < 10; i++) begin
            step((i < 4) ? R_PH : 6'd0, 1'b1);
            if (dllp_valid && last_hdr < 0) last_hdr = int'(dllp_hdr_fc);
        end
        chk("post_reset_init_hdr", 32'(last_hdr), 32'd20);

        // Completion header traffic plus a timer wrap.
        do_reset();
        last_hdr = -1;
        n_cpl = 0;
        for (int i = 0; i < 20 + TC + 10; i++) begin
            step((i < 20) ? R_CH : 6'd0, 1'b1);
            if (dllp_valid && dllp_type == 2'd2) begin
                n_cpl++;
                last_hdr = int'(dllp_hdr_fc);
            end
        end
`ifdef FC_INFINITE_CPL_EN
        chk("cpl_never_sent", 32'(n_cpl), 32'd0);
`else
        chk("cpl_last_hdr", 32'(last_hdr), 32'd36);
`endif

        // Randomized traffic with bursty back-pressure.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] r;
            for (int b = 0; b < 6; b++) r[b] = ($urandom_range(0, 2) == 0);
            step(r, ((i / 40) % 5 == 4) ? 1'b0 : ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
